// File: rtl/alu_wb_pkg.sv
// rtl/alu_wb_pkg.sv - shared writeback types: privilege constants, sequencer states, result record
package alu_wb_pkg;

    localparam int WB_XLEN  = 64;
    localparam int WB_ITAGW = 8;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic {
        WB_IDLE     = 1'b0,
        WB_CSR_WAIT = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [WB_ITAGW-1:0] itag;
        logic [WB_XLEN-1:0]  pc;
        logic [1:0]          priv;
        logic [4:0]          rd;
        logic                rdwe;
        logic [11:0]         csra;
        logic                csrwe;
        logic [WB_XLEN-1:0]  data1;
        logic [WB_XLEN-1:0]  data2;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - 2-entry in-order result buffer with flush that can preserve the head
module wb_fifo
    import alu_wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  logic      keep_head,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    wb_entry_t  mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= rd_ptr ^ pop;
            // A head held for an outstanding CSR write survives the flush unless it leaves now
            if (keep_head && !pop) begin
                count  <= 2'd1;
                wr_ptr <= ~rd_ptr;
            end else begin
                count  <= 2'd0;
                wr_ptr <= rd_ptr ^ pop;
            end
        end else begin
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            count  <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/alu_wb.sv
// rtl/alu_wb.sv - ALU writeback stage: buffers results, sequences CSR writes, drives GPR write and retire
module alu_wb
    import alu_wb_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int ITAGW = 8
) (
    input  logic             WBi_CLK,
    input  logic             WBi_RST,
    input  logic             WBi_Flush,
    input  logic             PIP_WBi_MSC_valid,
    input  logic [ITAGW-1:0] PIP_WBi_INFO_itag,
    input  logic [XLEN-1:0]  PIP_WBi_INFO_pc,
    input  logic [1:0]       PIP_WBi_INFO_priv,
    input  logic [4:0]       PIP_WBi_INFO_rd,
    input  logic             PIP_WBi_INFO_rdwe,
    input  logic [11:0]      PIP_WBi_INFO_csra,
    input  logic             PIP_WBi_INFO_csrwe,
    input  logic [XLEN-1:0]  PIP_WBi_DATA_data1,
    input  logic [XLEN-1:0]  PIP_WBi_DATA_data2,
    output logic             PIP_WBo_FC_ready,
    output logic             GPR_WBo_we,
    output logic [4:0]       GPR_WBo_addr,
    output logic [XLEN-1:0]  GPR_WBo_data,
    output logic             CSR_WBo_we,
    output logic [11:0]      CSR_WBo_addr,
    output logic [XLEN-1:0]  CSR_WBo_data,
    input  logic             CSR_WBi_ack,
    output logic             CMT_WBo_valid,
    output logic [ITAGW-1:0] CMT_WBo_itag,
    output logic [XLEN-1:0]  CMT_WBo_pc,
    output logic [1:0]       CMT_WBo_priv
);

    wb_state_e state;
    wb_state_e state_nxt;
    wb_entry_t in_entry;
    wb_entry_t head;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      retire;
    logic      csr_issue;

    assign PIP_WBo_FC_ready = !full;
    assign push = PIP_WBi_MSC_valid && !full && !WBi_Flush;

    always_comb begin
        in_entry       = '0;
        in_entry.itag  = WB_ITAGW'(PIP_WBi_INFO_itag);
        in_entry.pc    = WB_XLEN'(PIP_WBi_INFO_pc);
        in_entry.priv  = PIP_WBi_INFO_priv;
        in_entry.rd    = PIP_WBi_INFO_rd;
        in_entry.rdwe  = PIP_WBi_INFO_rdwe;
        in_entry.csra  = PIP_WBi_INFO_csra;
        in_entry.csrwe = PIP_WBi_INFO_csrwe;
        in_entry.data1 = WB_XLEN'(PIP_WBi_DATA_data1);
        in_entry.data2 = WB_XLEN'(PIP_WBi_DATA_data2);
    end

    wb_fifo u_fifo (
        .clk       (WBi_CLK),
        .rst       (WBi_RST),
        .push      (push),
        .pop       (pop),
        .flush     (WBi_Flush),
        .keep_head (state == WB_CSR_WAIT),
        .din       (in_entry),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge WBi_CLK) begin
        if (WBi_RST) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE:     if (!empty && !WBi_Flush && head.csrwe) state_nxt = WB_CSR_WAIT;
            WB_CSR_WAIT: if (CSR_WBi_ack) state_nxt = WB_IDLE;
            default:     state_nxt = WB_IDLE;
        endcase
    end

    // The head is only examined from the registered FIFO state, so a fresh push is never popped early
    always_comb begin
        pop       = 1'b0;
        retire    = 1'b0;
        csr_issue = 1'b0;
        case (state)
            WB_IDLE: begin
                if (!empty && !WBi_Flush) begin
                    if (head.csrwe) begin
                        csr_issue = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        retire = 1'b1;
                    end
                end
            end
            WB_CSR_WAIT: begin
                if (CSR_WBi_ack) begin
                    pop    = 1'b1;
                    retire = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge WBi_CLK) begin
        if (WBi_RST) begin
            GPR_WBo_we    <= 1'b0;
            GPR_WBo_addr  <= '0;
            GPR_WBo_data  <= '0;
            CSR_WBo_we    <= 1'b0;
            CSR_WBo_addr  <= '0;
            CSR_WBo_data  <= '0;
            CMT_WBo_valid <= 1'b0;
            CMT_WBo_itag  <= '0;
            CMT_WBo_pc    <= '0;
            CMT_WBo_priv  <= PRIV_M;
        end else begin
            GPR_WBo_we    <= retire && head.rdwe && (head.rd != 5'd0);
            CMT_WBo_valid <= retire;
            if (retire) begin
                GPR_WBo_addr <= head.rd;
                GPR_WBo_data <= head.data1[XLEN-1:0];
                CMT_WBo_itag <= head.itag[ITAGW-1:0];
                CMT_WBo_pc   <= head.pc[XLEN-1:0];
                CMT_WBo_priv <= head.priv;
            end
            if (csr_issue) begin
                CSR_WBo_we   <= 1'b1;
                CSR_WBo_addr <= head.csra;
                CSR_WBo_data <= head.data2[XLEN-1:0];
            end else if (retire) begin
                CSR_WBo_we   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_wb.sv
// tb/tb_alu_wb.sv - randomized and directed scoreboard bench for alu_wb
module tb_alu_wb;

    typedef struct {
        logic [7:0]  itag;
        logic [63:0] pc;
        logic [1:0]  priv;
        logic [4:0]  rd;
        logic        rdwe;
        logic [11:0] csra;
        logic        csrwe;
        logic [63:0] data1;
        logic [63:0] data2;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_flush;
    logic        in_valid;
    logic        in_ack;
    ent_t        in_e;

    logic        ready;
    logic        gpr_we;
    logic [4:0]  gpr_addr;
    logic [63:0] gpr_data;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [63:0] csr_data;
    logic        cmt_valid;
    logic [7:0]  cmt_itag;
    logic [63:0] cmt_pc;
    logic [1:0]  cmt_priv;

    always #5 clk = ~clk;

    alu_wb #(.XLEN(64), .ITAGW(8)) dut (
        .WBi_CLK            (clk),
        .WBi_RST            (rst),
        .WBi_Flush          (in_flush),
        .PIP_WBi_MSC_valid  (in_valid),
        .PIP_WBi_INFO_itag  (in_e.itag),
        .PIP_WBi_INFO_pc    (in_e.pc),
        .PIP_WBi_INFO_priv  (in_e.priv),
        .PIP_WBi_INFO_rd    (in_e.rd),
        .PIP_WBi_INFO_rdwe  (in_e.rdwe),
        .PIP_WBi_INFO_csra  (in_e.csra),
        .PIP_WBi_INFO_csrwe (in_e.csrwe),
        .PIP_WBi_DATA_data1 (in_e.data1),
        .PIP_WBi_DATA_data2 (in_e.data2),
        .PIP_WBo_FC_ready   (ready),
        .GPR_WBo_we         (gpr_we),
        .GPR_WBo_addr       (gpr_addr),
        .GPR_WBo_data       (gpr_data),
        .CSR_WBo_we         (csr_we),
        .CSR_WBo_addr       (csr_addr),
        .CSR_WBo_data       (csr_data),
        .CSR_WBi_ack        (in_ack),
        .CMT_WBo_valid      (cmt_valid),
        .CMT_WBo_itag       (cmt_itag),
        .CMT_WBo_pc         (cmt_pc),
        .CMT_WBo_priv       (cmt_priv)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a queue of accepted results plus the externally visible outputs they imply
    ent_t        q[$];
    bit          waiting;
    bit          known;
    bit          last_push;
    logic        e_gpr_we, e_csr_we, e_cmt;
    logic [4:0]  e_gpr_addr;
    logic [63:0] e_gpr_data, e_csr_data, e_pc;
    logic [11:0] e_csr_addr;
    logic [7:0]  e_itag;
    logic [1:0]  e_priv;

    int dut_csr_cycles;
    int dut_nrdy;
    int dut_commits;
    logic [7:0] dut_last_itag;

    task automatic model_retire(input ent_t e);
        e_cmt  = 1'b1;
        e_itag = e.itag;
        e_pc   = e.pc;
        e_priv = e.priv;
        e_gpr_we = e.rdwe && (e.rd != 5'd0);
        if (e_gpr_we) begin
            e_gpr_addr = e.rd;
            e_gpr_data = e.data1;
        end
    endtask

    task automatic step();
        bit   space;
        bit   chk_all;
        ent_t h;
        if (known) check("ready", ready, q.size() < 2);
        space     = q.size() < 2;
        last_push = in_valid && space && !in_flush && !rst;
        chk_all   = rst;
        e_gpr_we  = 1'b0;
        e_cmt     = 1'b0;
        if (rst) begin
            q.delete();
            waiting = 0;
            known = 1;
            e_csr_we = 0; e_gpr_addr = 0; e_gpr_data = 0; e_csr_addr = 0; e_csr_data = 0;
            e_itag = 0; e_pc = 0; e_priv = 2'b11;
        end else begin
            if (waiting) begin
                if (in_ack) begin
                    h = q.pop_front();
                    model_retire(h);
                    waiting  = 0;
                    e_csr_we = 1'b0;
                end
                if (in_flush) begin
                    while (q.size() > (in_ack ? 0 : 1)) void'(q.pop_back());
                end
            end else if (in_flush) begin
                q.delete();
            end else if (q.size() > 0) begin
                if (q[0].csrwe) begin
                    waiting    = 1;
                    e_csr_we   = 1'b1;
                    e_csr_addr = q[0].csra;
                    e_csr_data = q[0].data2;
                end else begin
                    h = q.pop_front();
                    model_retire(h);
                end
            end
            if (last_push) q.push_back(in_e);
        end
        @(posedge clk);
        @(negedge clk);
        check("gpr_we", gpr_we, e_gpr_we);
        check("cmt_valid", cmt_valid, e_cmt);
        check("csr_we", csr_we, e_csr_we);
        if (e_gpr_we || chk_all) begin
            check("gpr_addr", gpr_addr, e_gpr_addr);
            check("gpr_data", gpr_data, e_gpr_data);
        end
        if (e_cmt || chk_all) begin
            check("cmt_itag", cmt_itag, e_itag);
            check("cmt_pc", cmt_pc, e_pc);
            check("cmt_priv", cmt_priv, e_priv);
        end
        if (e_csr_we || chk_all) begin
            check("csr_addr", csr_addr, e_csr_addr);
            check("csr_data", csr_data, e_csr_data);
        end
        if (csr_we === 1'b1) dut_csr_cycles++;
        if (ready === 1'b0) dut_nrdy++;
        if (cmt_valid === 1'b1) begin
            dut_commits++;
            dut_last_itag = cmt_itag;
        end
    endtask

    function automatic ent_t mk(input logic [7:0] itag, input logic [4:0] rd, input logic [63:0] d1,
                                input logic csrwe, input logic [11:0] csra, input logic [63:0] d2);
        ent_t e;
        e.itag = itag; e.pc = 64'h8000_0000 + 64'(itag) * 4; e.priv = 2'b11;
        e.rd = rd; e.rdwe = 1'b1; e.csra = csra; e.csrwe = csrwe; e.data1 = d1; e.data2 = d2;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.itag  = 8'($urandom);
        e.pc    = {$urandom, $urandom};
        e.priv  = 2'($urandom);
        e.rd    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        e.rdwe  = 1'($urandom);
        e.csra  = 12'($urandom);
        e.csrwe = ($urandom_range(0, 3) == 0);
        e.data1 = {$urandom, $urandom};
        e.data2 = {$urandom, $urandom};
        return e;
    endfunction

    task automatic idle(input int n);
        in_valid = 0; in_flush = 0; in_ack = 0; rst = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reset_counters();
        dut_csr_cycles = 0; dut_nrdy = 0; dut_commits = 0; dut_last_itag = 8'hxx;
    endtask

    task automatic wait_csr_issue();
        for (int i = 0; i < 8 && !e_csr_we; i++) step();
        check("csr_issue_bound", e_csr_we, 1'b1);
    endtask

    initial begin
        int sent;
        int wec;
        known = 0;
        waiting = 0;
        in_e = mk(0, 0, 0, 0, 0, 0);
        in_valid = 0; in_flush = 0; in_ack = 0;

        // reset, then ready must be high straight away
        rst = 1;
        step();
        step();
        idle(1);
        check("ready_after_reset", ready, 1'b1);

        // back-to-back plain results
        reset_counters();
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_e = mk(8'(i + 1), 5'(i + 5), 64'(16 * (i + 1)), 0, 0, 0);
            step();
        end
        idle(4);
        check("b2b_commits", dut_commits, 4);
        check("b2b_last_itag", dut_last_itag, 8'd4);
        check("b2b_ready_drops", dut_nrdy, 0);

        // CSR write stall: ack on the fifth cycle of the request
        reset_counters();
        in_valid = 1;
        in_e = mk(7, 3, 64'h55, 1, 12'h300, 64'hAA);
        step();
        sent = 0; wec = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (sent < 2);
            in_e = mk(8'(10 + sent), 5'(10 + sent), 64'(256 + sent), 0, 0, 0);
            if (e_csr_we) wec++;
            in_ack = e_csr_we && (wec == 5);
            step();
            if (last_push) sent++;
        end
        idle(3);
        check("csr_hold_cycles", dut_csr_cycles, 5);
        check("csr_ready_low_seen", dut_nrdy > 0, 1'b1);
        check("csr_commits", dut_commits, 3);

        // flush removes the queued head and blocks that cycle's push
        reset_counters();
        in_valid = 1;
        in_e = mk(20, 1, 64'h1, 0, 0, 0);
        step();
        in_e = mk(21, 2, 64'h2, 0, 0, 0);
        in_flush = 1;
        step();
        idle(3);
        check("flush_commits", dut_commits, 0);

        // flush while the CSR head is waiting: only the head retires
        reset_counters();
        in_valid = 1;
        in_e = mk(9, 4, 64'h99, 1, 12'h341, 64'h77);
        step();
        in_e = mk(11, 6, 64'hBB, 0, 0, 0);
        step();
        in_valid = 0;
        wait_csr_issue();
        in_flush = 1;
        step();
        in_flush = 0;
        idle(2);
        in_ack = 1;
        step();
        idle(3);
        check("flush_wait_commits", dut_commits, 1);
        check("flush_wait_itag", dut_last_itag, 8'd9);

        // rd=0 retires without a GPR write, then reset abandons a CSR request
        reset_counters();
        in_valid = 1;
        in_e = mk(30, 0, 64'hDEAD, 0, 0, 0);
        step();
        in_e = mk(31, 7, 64'hBEEF, 1, 12'h305, 64'h1234);
        step();
        in_valid = 0;
        wait_csr_issue();
        rst = 1;
        in_ack = 1;
        step();
        rst = 0;
        in_ack = 0;
        idle(3);
        check("rd0_reset_commits", dut_commits, 1);
        check("rd0_reset_itag", dut_last_itag, 8'd30);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_e     = rnd_ent();
            in_flush = ($urandom_range(0, 19) == 0);
            in_ack   = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 299) == 0);
            step();
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
